apb_req_master: RTL

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_req_master.sv | 125 ++++++++++++
 1 files changed

// File: rtl/apb_req_master.sv
// Command/response to APB bridge: accepts one command at a time, runs a single
// APB transfer and returns the completer's answer (or a timeout abort).
module apb_req_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [STRB_WIDTH-1:0] PSTRB,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   input  logic [DATA_WIDTH-1:0] PRDATA
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // Encoding is {rsp_valid, PSEL, PENABLE} so the APB controls are plain flop bits.
   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      SETUP  = 3'b010,
      ACCESS = 3'b011,
      RESP   = 3'b100
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_inc;
   logic             cmd_fire;
   logic             done;
   logic             abort;

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      wait_inc  = wait_cnt + CNT_W'(1);
      done      = (state == ACCESS) && PREADY;
      abort     = (TIMEOUT != 0) && (state == ACCESS) && !PREADY &&
                  (wait_inc == CNT_W'(TIMEOUT));
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = SETUP;
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: begin
            if (done || abort) state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               cmd_ready = 1'b1;
               state_nxt = cmd_valid ? SETUP : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      cmd_fire = cmd_valid && cmd_ready;
   end

   assign PSEL      = state[1];
   assign PENABLE   = state[0];
   assign rsp_valid = state[2];

   always_ff @(posedge PCLK) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   // Request fields only change on a command handshake, which keeps them
   // stable for the whole SETUP/ACCESS window.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
         PSTRB  <= '0;
      end else if (cmd_fire) begin
         PWRITE <= cmd_write;
         PADDR  <= cmd_addr;
         PWDATA <= cmd_write ? cmd_wdata : '0;
         PSTRB  <= cmd_write ? cmd_strb  : '0;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn)                         wait_cnt <= '0;
      else if (cmd_fire)                    wait_cnt <= '0;
      else if (state == ACCESS && !PREADY)  wait_cnt <= wait_inc;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (done) begin
         rsp_rdata   <= PWRITE ? '0 : PRDATA;
         rsp_err     <= PSLVERR;
         rsp_timeout <= 1'b0;
      end else if (abort) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b1;
         rsp_timeout <= 1'b1;
      end
   end

endmodule
